// File: rtl/debouncer.sv
// rtl/debouncer.sv - push-button debouncer with clean level and press/release strobes
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic PB,
  output logic PB_state,
  output logic PB_down,
  output logic PB_up
);

  // Terminal count: the mismatch run that reaches this value commits the new level.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] cnt;

  // Two-flop synchroniser; only sync2 is allowed to reach the debounce logic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= PB;
      sync2 <= sync1;
    end
  end

  // Count consecutive mismatch cycles; any return to the current level restarts the run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      PB_state <= 1'b0;
      PB_down  <= 1'b0;
      PB_up    <= 1'b0;
    end else if (sync2 == PB_state) begin
      cnt     <= '0;
      PB_down <= 1'b0;
      PB_up   <= 1'b0;
    end else if (cnt != CNT_LAST) begin
      cnt     <= cnt + CNT_ONE;
      PB_down <= 1'b0;
      PB_up   <= 1'b0;
    end else begin
      // Strobes are registered alongside the level so they coincide with its first new cycle.
      cnt      <= '0;
      PB_state <= ~PB_state;
      PB_down  <= ~PB_state;
      PB_up    <= PB_state;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// tb/tb_debouncer.sv - directed self-checking bench for debouncer
module tb_debouncer;

  localparam int D = 200;

  logic clk;
  logic reset;
  logic PB;
  logic PB_state;
  logic PB_down;
  logic PB_up;

  int vectors;
  int miscompares;

  debouncer #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .PB       (PB),
    .PB_state (PB_state),
    .PB_down  (PB_down),
    .PB_up    (PB_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // step n cycles, recording when the level changes and when strobes fire (step indices are 1-based)
  task automatic watch(input int n, output int chg_step, output int n_chg,
                       output int n_down, output int down_step,
                       output int n_up, output int up_step, output int n_both);
    logic prev;
    prev = PB_state;
    chg_step = 0; n_chg = 0; n_down = 0; down_step = 0;
    n_up = 0; up_step = 0; n_both = 0;
    for (int i = 1; i <= n; i++) begin
      step();
      if (PB_state !== prev) begin
        n_chg++;
        if (chg_step == 0) chg_step = i;
      end
      prev = PB_state;
      if (PB_down === 1'b1) begin
        n_down++;
        if (down_step == 0) down_step = i;
      end
      if (PB_up === 1'b1) begin
        n_up++;
        if (up_step == 0) up_step = i;
      end
      if (PB_down === 1'b1 && PB_up === 1'b1) n_both++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    PB    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) PB = ~PB;
      step();
      vectors++;
      if ({PB_state, PB_down, PB_up} !== 3'b000 || dut.cnt !== 16'd0) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: state/down/up=%b%b%b cnt=%0d want 000 cnt=0",
                 i, PB_state, PB_down, PB_up, dut.cnt);
      end
    end
    PB    = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (PB_state !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: PB_state=%b want 0", PB_state);
    end
  endtask

  task automatic test_bouncy_press();
    int cs, nc, nd, ds, nu, us, nb;
    int tc, td, tu;
    tc = 0; td = 0; tu = 0;
    PB = 1'b1; watch(40, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    PB = 1'b0; watch(80, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    PB = 1'b1; watch(80, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    PB = 1'b0; watch(80, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    vectors++;
    if (tc != 0 || td != 0 || tu != 0) begin
      miscompares++;
      $display("FAIL press_bounce_quiet: changes=%0d downs=%0d ups=%0d want 0 0 0", tc, td, tu);
    end
    PB = 1'b1;
    watch(4000, cs, nc, nd, ds, nu, us, nb);
    vectors++;
    if (cs != D + 2 || nc != 1) begin
      miscompares++;
      $display("FAIL press_latency: change_step=%0d changes=%0d want %0d 1", cs, nc, D + 2);
    end
    vectors++;
    if (nd != 1 || ds != D + 2) begin
      miscompares++;
      $display("FAIL press_down_strobe: cycles=%0d at=%0d want 1 at %0d", nd, ds, D + 2);
    end
    vectors++;
    if (nu != 0 || PB_state !== 1'b1) begin
      miscompares++;
      $display("FAIL press_no_up: ups=%0d state=%b want 0 1", nu, PB_state);
    end
  endtask

  task automatic test_clean_release();
    int cs, nc, nd, ds, nu, us, nb;
    PB = 1'b0;
    watch(400, cs, nc, nd, ds, nu, us, nb);
    vectors++;
    if (cs != D + 2 || nc != 1 || PB_state !== 1'b0) begin
      miscompares++;
      $display("FAIL clean_release_latency: change_step=%0d changes=%0d state=%b want %0d 1 0",
               cs, nc, PB_state, D + 2);
    end
    vectors++;
    if (nu != 1 || us != D + 2 || nd != 0) begin
      miscompares++;
      $display("FAIL clean_release_strobes: ups=%0d at=%0d downs=%0d want 1 at %0d 0",
               nu, us, nd, D + 2);
    end
  endtask

  task automatic test_bouncy_release();
    int cs, nc, nd, ds, nu, us, nb;
    int tc, td, tu;
    PB = 1'b1;
    watch(300, cs, nc, nd, ds, nu, us, nb);
    vectors++;
    if (PB_state !== 1'b1 || nd != 1) begin
      miscompares++;
      $display("FAIL rerelease_setup: state=%b downs=%0d want 1 1", PB_state, nd);
    end
    tc = 0; td = 0; tu = 0;
    PB = 1'b0; watch(40, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    PB = 1'b1; watch(80, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    PB = 1'b0; watch(80, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    PB = 1'b1; watch(80, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    vectors++;
    if (tc != 0 || td != 0 || tu != 0) begin
      miscompares++;
      $display("FAIL release_bounce_quiet: changes=%0d downs=%0d ups=%0d want 0 0 0", tc, td, tu);
    end
    PB = 1'b0;
    watch(400, cs, nc, nd, ds, nu, us, nb);
    vectors++;
    if (cs != D + 2 || nu != 1 || us != D + 2) begin
      miscompares++;
      $display("FAIL bouncy_release_up: change_step=%0d ups=%0d at=%0d want %0d 1 at %0d",
               cs, nu, us, D + 2, D + 2);
    end
    vectors++;
    if (nd != 0 || PB_state !== 1'b0) begin
      miscompares++;
      $display("FAIL bouncy_release_no_down: downs=%0d state=%b want 0 0", nd, PB_state);
    end
  endtask

  task automatic test_glitch_boundary();
    int cs, nc, nd, ds, nu, us, nb;
    int tc, td, tu;
    // one cycle short of the threshold: must be rejected
    PB = 1'b1; watch(D - 1, cs, nc, nd, ds, nu, us, nb); tc = nc; td = nd; tu = nu;
    PB = 1'b0; watch(400, cs, nc, nd, ds, nu, us, nb); tc += nc; td += nd; tu += nu;
    vectors++;
    if (tc != 0 || td != 0 || tu != 0 || PB_state !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_short: changes=%0d downs=%0d ups=%0d state=%b want 0 0 0 0",
               tc, td, tu, PB_state);
    end
    // exactly the threshold: toggles up, then the return to 0 is itself debounced
    PB = 1'b1; watch(D, cs, nc, nd, ds, nu, us, nb); tc = nc;
    vectors++;
    if (tc != 0) begin
      miscompares++;
      $display("FAIL glitch_exact_early: changes=%0d want 0", tc);
    end
    PB = 1'b0; watch(400, cs, nc, nd, ds, nu, us, nb);
    vectors++;
    if (nd != 1 || ds != 2) begin
      miscompares++;
      $display("FAIL glitch_exact_down: downs=%0d at=%0d want 1 at 2", nd, ds);
    end
    vectors++;
    if (nu != 1 || us != D + 2 || nc != 2 || nb != 0) begin
      miscompares++;
      $display("FAIL glitch_exact_up: ups=%0d at=%0d changes=%0d both=%0d want 1 at %0d 2 0",
               nu, us, nc, nb, D + 2);
    end
  endtask

  task automatic test_reset_mid_count();
    int cs, nc, nd, ds, nu, us, nb;
    PB = 1'b1;
    for (int i = 0; i < 152; i++) step();
    vectors++;
    if (dut.cnt !== 16'd150 || PB_state !== 1'b0) begin
      miscompares++;
      $display("FAIL midcount_cnt: cnt=%0d state=%b want 150 0", dut.cnt, PB_state);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (dut.cnt !== 16'd0 || {PB_state, PB_down, PB_up} !== 3'b000) begin
      miscompares++;
      $display("FAIL midcount_reset: cnt=%0d state/down/up=%b%b%b want 0 000",
               dut.cnt, PB_state, PB_down, PB_up);
    end
    reset = 1'b1;
    watch(400, cs, nc, nd, ds, nu, us, nb);
    vectors++;
    if (cs != D + 2 || nc != 1 || PB_state !== 1'b1) begin
      miscompares++;
      $display("FAIL midcount_latency: change_step=%0d changes=%0d state=%b want %0d 1 1",
               cs, nc, PB_state, D + 2);
    end
    vectors++;
    if (nd != 1 || ds != D + 2 || nu != 0) begin
      miscompares++;
      $display("FAIL midcount_strobe: downs=%0d at=%0d ups=%0d want 1 at %0d 0",
               nd, ds, nu, D + 2);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    PB          = 1'b0;
    test_reset();
    test_bouncy_press();
    test_clean_release();
    test_bouncy_release();
    test_glitch_boundary();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
